// File: rtl/hdmi_audio_tone_gen_if.sv
// hdmi_audio_tone_gen_if: tone configuration in, sample strobe/valid/words out.
interface hdmi_audio_tone_gen_if #(
  parameter int BIT_WIDTH   = 16,
  parameter int CHANNELS    = 2,
  parameter int PHASE_WIDTH = 24
);
  logic                            enable;
  logic [CHANNELS*PHASE_WIDTH-1:0] tone_step;
  logic [CHANNELS*2-1:0]           tone_mode;
  logic [CHANNELS*4-1:0]           tone_atten;
  logic                            sample_strobe;
  logic                            sample_valid;
  logic [CHANNELS*BIT_WIDTH-1:0]   audio_sample_word;
  modport master (
    output enable, tone_step, tone_mode, tone_atten,
    input  sample_strobe, sample_valid, audio_sample_word
  );
  modport slave (
    input  enable, tone_step, tone_mode, tone_atten,
    output sample_strobe, sample_valid, audio_sample_word
  );
endinterface

// File: rtl/hdmi_audio_tone_gen.sv
// hdmi_audio_tone_gen: fractional-NCO sample strobe plus per-channel saw/square/triangle tone synthesis.
module hdmi_audio_tone_gen #(
  parameter int CLK_HZ      = 25_200_000,
  parameter int AUDIO_RATE  = 48000,
  parameter int BIT_WIDTH   = 16,
  parameter int CHANNELS    = 2,
  parameter int PHASE_WIDTH = 24
) (
  input logic                   clk_pixel,
  input logic                   reset_n,
  hdmi_audio_tone_gen_if.slave  bus
);
  localparam int AW = $clog2(CLK_HZ) + 1;
  localparam int W  = BIT_WIDTH;
  localparam int PW = PHASE_WIDTH;
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX = ~MSB;
  if (AUDIO_RATE <= 0 || AUDIO_RATE >= CLK_HZ || W < 4 || CHANNELS < 1 || PW < W + 1) begin : g_bad_params
    $error("hdmi_audio_tone_gen: illegal parameter combination");
  end
  logic [AW-1:0] r_acc;
  logic [AW:0]   w_sum;
  logic          w_wrap;
  logic          r_strobe;
  logic          r_valid;
  assign w_sum  = {1'b0, r_acc} + (AW+1)'(AUDIO_RATE);
  assign w_wrap = w_sum >= (AW+1)'(CLK_HZ);
  // A strobe already issued still yields its valid even if enable drops.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_acc    <= bus.enable ? AW'(w_wrap ? w_sum - (AW+1)'(CLK_HZ) : w_sum) : '0;
      r_strobe <= bus.enable & w_wrap;
      r_valid  <= r_strobe;
    end
  end
  assign bus.sample_strobe = r_strobe;
  assign bus.sample_valid  = r_valid;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PW-1:0] r_phase;
    logic [W-1:0]  r_word;
    logic [W-1:0]  w_u;
    logic [W-1:0]  w_raw;
    logic [W-1:0]  w_shift;
    logic [1:0]    w_mode;
    logic [3:0]    w_atten;
    logic          w_msb;
    assign w_mode  = bus.tone_mode[c*2 +: 2];
    assign w_atten = bus.tone_atten[c*4 +: 4];
    assign w_msb   = r_phase[PW-1];
    assign w_u     = r_phase[PW-2 -: W];
    assign w_raw   = w_mode == 2'd0 ? r_phase[PW-1 -: W] ^ MSB :
                     w_mode == 2'd1 ? (w_msb ? MSB : MAX) :
                     w_mode == 2'd2 ? (w_msb ? ~w_u : w_u) ^ MSB : '0;
    assign w_shift = $signed(w_raw) >>> w_atten;
    always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
        r_phase <= '0;
        r_word  <= '0;
      end else begin
        r_phase <= !bus.enable ? '0 : r_strobe ? r_phase + bus.tone_step[c*PW +: PW] : r_phase;
        if (r_strobe) r_word <= w_shift;
      end
    end
    assign bus.audio_sample_word[c*W +: W] = r_word;
  end
endmodule
